search_window_scanner: RTL and testbench
========================================

SEARCH_WINDOW_SCANNER -- requirements
Module: search_window_scanner

Interface
REQ-001 SHALL have parameter blk_h, default 16, reference block height in pixels.
REQ-002 SHALL have parameter blk_w, default 16, reference block width in pixels.
REQ-003 SHALL have parameter search_blk_w, default 64, search window width in pixels.
REQ-004 SHALL have parameter search_blk_h, default 20, search window height in pixels.
REQ-005 SHALL derive blk_size = blk_h*blk_w, n_v = search_blk_h-blk_h, n_h = search_blk_w-blk_w, num_sums = n_v*n_h (default 4*48 = 192).
REQ-006 SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; rising edge
- reset  in  1  asynchronous, active-high
- blk_in_valid  in  1  reference/search block pair offered
- blk_in_ready  out  1  block pair accepted when high together with blk_in_valid
- ref_blk  in  blk_size  census bits; bit r*blk_w+c
- srch_blk  in  search_blk_w*search_blk_h  census bits; bit y*search_blk_w+x
- blk_index_in  in  16  block tag
- xors  out  blk_size  candidate XOR reference
- sum  out  8  popcount of xors, saturated
- out_coords  out  16  {vertical[15:8], horizontal[7:0]} candidate offset
- blk_index_o  out  16  tag of the block producing this sum
- sum_valid  out  1  xors/sum/out_coords/blk_index_o valid this cycle

Function
REQ-007 SHALL implement FSM states IDLE and SCAN; blk_in_ready = 1 only in IDLE.
REQ-008 SHALL, on a handshake in IDLE, register ref_blk, srch_blk and blk_index_in, then enter SCAN.
REQ-009 SHALL in SCAN issue exactly one candidate per cycle, num_sums per block, with no gaps.
REQ-010 SHALL order candidates vertical ascending 0..n_v-1 (outer) and horizontal descending n_h-1..0 (inner); the last candidate is {n_v-1, 0}.
REQ-011 SHALL form candidate bit r*blk_w+c = srch[(r+v)*search_blk_w + (c+h)] and xors = candidate ^ ref.
REQ-012 SHALL compute sum = min(popcount(xors), 255).
REQ-013 SHALL return to IDLE the cycle after issuing the last candidate, ignoring blk_in_valid during SCAN.
REQ-014 SHALL register all outputs, with all output fields of one candidate appearing in the same cycle.
REQ-015 SHALL assert sum_valid exactly 3 cycles after candidate issue (registers: xors, partial popcounts, final sum).
REQ-016 SHALL keep the pipeline in order; a new block's first result SHALL directly follow the previous block's last result plus one idle cycle.
REQ-017 SHALL provide no backpressure input; the downstream consumer accepts every sum_valid cycle.
REQ-018 SHALL hold output data at its last value when sum_valid = 0.

Reset
REQ-019 SHALL, on reset assertion, asynchronously set the state to IDLE, clear the counters, clear all pipeline valid bits, and zero xors, sum, out_coords, blk_index_o and sum_valid.
REQ-020 SHALL discard an in-flight scan on reset mid-SCAN, with no further sum_valid pulses for that block.
REQ-021 SHALL assert blk_in_ready in the first cycle after reset deasserts.

Structure
REQ-022 SHALL take the coords typedef (struct of 8-bit vertical and horizontal fields) and the default geometry constants from shared package block_matching_pkg.
REQ-023 SHALL implement the popcount in sub-module popcount_tree: 16-bit group sums registered in stage 2, a saturated total in stage 3.

Verification
REQ-024 SHALL cover: ref and srch all-zero, accept at edge T -> sum_valid high T+4..T+195 contiguous, sum = 0, first out_coords 0x002F, last out_coords 0x0300.
REQ-025 SHALL cover: ref all-ones, srch all-zero -> every sum = 255 (saturated from 256), xors all-ones.
REQ-026 SHALL cover: random srch with ref copied at v = 2, h = 10 -> sum = 0 at out_coords 0x020A, with other coordinates matching the model popcount.
REQ-027 SHALL cover: back-to-back blocks tagged 0x0000 and 0x0001 -> 192 results each with the correct blk_index_o, one idle cycle between them, blk_in_ready high at T+193.
REQ-028 SHALL cover: reset asserted at result 50 -> outputs zeroed immediately, no further sum_valid, blk_in_ready = 1 after release, next block scans from 0x002F.

Source files
------------

// File: rtl/block_matching_pkg.sv
// Shared definitions for the block-matching datapath: default search
// geometry, the candidate coordinate record, scanner FSM states and the
// popcount helpers used by the sum pipeline.
package block_matching_pkg;

    localparam int DEF_BLK_H        = 16;
    localparam int DEF_BLK_W        = 16;
    localparam int DEF_SEARCH_BLK_W = 64;
    localparam int DEF_SEARCH_BLK_H = 20;

    // Width of one first-level popcount group.
    localparam int POP_GRP_W = 16;

    // Candidate offset inside the search window.
    typedef struct packed {
        logic [7:0] vertical;
        logic [7:0] horizontal;
    } coords_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

    // Number of set bits in one 16-bit group (0..16).
    function automatic logic [4:0] popcount16(input logic [15:0] d);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, d[i]};
        end
        return cnt;
    endfunction

    // Clamp a wide count into the 8-bit sum field.
    function automatic logic [7:0] sat_u8(input logic [15:0] v);
        logic [7:0] res;
        if (v > 16'd255) begin
            res = 8'd255;
        end else begin
            res = v[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/popcount_tree.sv
// Two-stage popcount of the registered XOR vector: per-group counts are
// registered first, then the saturated total. Each stage only loads when
// its enable says the data feeding it is a real candidate, so the final
// sum holds its value between bursts.
module popcount_tree
    import block_matching_pkg::*;
#(
    parameter int data_w = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              grp_en_i,
    input  logic              sum_en_i,
    input  logic [data_w-1:0] data_i,
    output logic [7:0]        sum_o
);

    localparam int N_GRP = data_w / POP_GRP_W;

    logic [4:0]  grp_pc_s [N_GRP];
    logic [4:0]  grp_q    [N_GRP];
    logic [15:0] total_d;
    logic [7:0]  sum_q;

    for (genvar g = 0; g < N_GRP; g++) begin : g_grp
        assign grp_pc_s[g] = popcount16(data_i[g*POP_GRP_W +: POP_GRP_W]);
    end

    // Register the per-group counts of the incoming XOR vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grp_q <= '{default: 5'd0};
        end else if (grp_en_i) begin
            grp_q <= grp_pc_s;
        end
    end

    // Add up all group counts into one total.
    always_comb begin
        total_d = 16'd0;
        for (int g = 0; g < N_GRP; g++) begin
            total_d = total_d + {11'd0, grp_q[g]};
        end
    end

    // Register the saturated total; 256 set bits clamp to 255.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else if (sum_en_i) begin
            sum_q <= sat_u8(total_d);
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/search_window_scanner.sv
// Census-transform block matcher front end. Accepts one reference block and
// its search window, then walks every candidate offset (vertical ascending,
// horizontal descending) one per cycle. Each candidate is XORed with the
// reference and popcounted through a three-register pipeline:
//   stage 1: XOR vector, stage 2: group counts, stage 3: saturated sum.
// All output fields of a candidate leave together from stage 3 and hold
// when no result is valid.
module search_window_scanner
    import block_matching_pkg::*;
#(
    parameter int blk_h        = DEF_BLK_H,
    parameter int blk_w        = DEF_BLK_W,
    parameter int search_blk_w = DEF_SEARCH_BLK_W,
    parameter int search_blk_h = DEF_SEARCH_BLK_H
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 blk_in_valid,
    output logic                                 blk_in_ready,
    input  logic [blk_h*blk_w-1:0]               ref_blk,
    input  logic [search_blk_w*search_blk_h-1:0] srch_blk,
    input  logic [15:0]                          blk_index_in,
    output logic [blk_h*blk_w-1:0]               xors,
    output logic [7:0]                           sum,
    output logic [15:0]                          out_coords,
    output logic [15:0]                          blk_index_o,
    output logic                                 sum_valid
);

    localparam int BLK_SIZE  = blk_h * blk_w;
    localparam int SRCH_SIZE = search_blk_w * search_blk_h;
    localparam int N_V       = search_blk_h - blk_h;
    localparam int N_H       = search_blk_w - blk_w;
    localparam int OFS_W     = $clog2(SRCH_SIZE);

    localparam logic [7:0] V_LAST  = 8'(N_V - 1);
    localparam logic [7:0] H_FIRST = 8'(N_H - 1);

    // Control and captured block
    scan_state_t          state_q;
    logic                 ready_q;
    logic [7:0]           v_q;
    logic [7:0]           h_q;
    logic [BLK_SIZE-1:0]  ref_q;
    logic [SRCH_SIZE-1:0] srch_q;
    logic [15:0]          tag_q;

    // Candidate extraction
    logic [OFS_W-1:0]     ofs_s;
    logic [BLK_SIZE-1:0]  cand_s;

    // Pipeline registers
    logic                 vld1_q;
    logic [BLK_SIZE-1:0]  xors1_q;
    coords_t              coords1_q;
    logic [15:0]          tag1_q;

    logic                 vld2_q;
    logic [BLK_SIZE-1:0]  xors2_q;
    coords_t              coords2_q;
    logic [15:0]          tag2_q;

    logic                 vld3_q;
    logic [BLK_SIZE-1:0]  xors3_q;
    coords_t              coords3_q;
    logic [15:0]          tag3_q;
    logic [7:0]           sum3_s;

    // Scan FSM: capture a block pair in IDLE, then step through all offsets.
    // The inner loop counts horizontal offsets down so the wrap test is a
    // compare against zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            v_q     <= 8'd0;
            h_q     <= 8'd0;
            ref_q   <= '0;
            srch_q  <= '0;
            tag_q   <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (blk_in_valid) begin
                        ref_q   <= ref_blk;
                        srch_q  <= srch_blk;
                        tag_q   <= blk_index_in;
                        v_q     <= 8'd0;
                        h_q     <= H_FIRST;
                        state_q <= ST_SCAN;
                        ready_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    if (h_q == 8'd0) begin
                        if (v_q == V_LAST) begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            v_q <= v_q + 8'd1;
                            h_q <= H_FIRST;
                        end
                    end else begin
                        h_q <= h_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Bit offset of the candidate's top-left pixel inside the search window.
    assign ofs_s = OFS_W'(v_q) * OFS_W'(search_blk_w) + OFS_W'(h_q);

    // Candidate bit r*blk_w+c comes from window pixel (r+v, c+h).
    for (genvar r = 0; r < blk_h; r++) begin : g_row
        for (genvar c = 0; c < blk_w; c++) begin : g_col
            assign cand_s[r*blk_w + c] = srch_q[ofs_s + OFS_W'(r*search_blk_w + c)];
        end
    end

    // Stage 1: XOR the issued candidate with the reference and tag it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld1_q    <= 1'b0;
            xors1_q   <= '0;
            coords1_q <= '0;
            tag1_q    <= 16'd0;
        end else begin
            vld1_q <= (state_q == ST_SCAN);
            if (state_q == ST_SCAN) begin
                xors1_q   <= cand_s ^ ref_q;
                coords1_q <= '{vertical: v_q, horizontal: h_q};
                tag1_q    <= tag_q;
            end
        end
    end

    // Stage 2: carry the side fields alongside the group popcounts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld2_q    <= 1'b0;
            xors2_q   <= '0;
            coords2_q <= '0;
            tag2_q    <= 16'd0;
        end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
                xors2_q   <= xors1_q;
                coords2_q <= coords1_q;
                tag2_q    <= tag1_q;
            end
        end
    end

    popcount_tree #(
        .data_w (BLK_SIZE)
    ) u_popcount (
        .clk      (clk),
        .reset    (reset),
        .grp_en_i (vld1_q),
        .sum_en_i (vld2_q),
        .data_i   (xors1_q),
        .sum_o    (sum3_s)
    );

    // Stage 3: output registers, aligned with the popcount tree's final sum.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld3_q    <= 1'b0;
            xors3_q   <= '0;
            coords3_q <= '0;
            tag3_q    <= 16'd0;
        end else begin
            vld3_q <= vld2_q;
            if (vld2_q) begin
                xors3_q   <= xors2_q;
                coords3_q <= coords2_q;
                tag3_q    <= tag2_q;
            end
        end
    end

    assign blk_in_ready = ready_q;
    assign xors         = xors3_q;
    assign sum          = sum3_s;
    assign out_coords   = coords3_q;
    assign blk_index_o  = tag3_q;
    assign sum_valid    = vld3_q;

endmodule

// File: tb/tb_search_window_scanner.sv
// Self-checking bench for search_window_scanner: a table of block pairs is
// scanned one after another while a scoreboard holds the model's expected
// result for every candidate; hand-written sequences cover back-to-back
// blocks and a reset in the middle of a scan.
// Cycle bookkeeping: cyc counts rising edges and is read on falling edges,
// so a value seen with cyc == K was launched by edge K (visible at the
// sampling edge K+1). A block accepted on edge T shows its first result
// with cyc == T+3 and its last with cyc == T+194.
module tb_search_window_scanner;

    localparam int BH = 16;
    localparam int BW = 16;
    localparam int SW = 64;
    localparam int SH = 20;
    localparam int NV = SH - BH;
    localparam int NH = SW - BW;
    localparam int NS = NV * NH;

    logic          clk = 1'b0;
    logic          reset;
    logic          blk_in_valid;
    logic          blk_in_ready;
    logic [255:0]  ref_blk;
    logic [1279:0] srch_blk;
    logic [15:0]   blk_index_in;
    logic [255:0]  xors;
    logic [7:0]    sum;
    logic [15:0]   out_coords;
    logic [15:0]   blk_index_o;
    logic          sum_valid;

    search_window_scanner #(
        .blk_h        (BH),
        .blk_w        (BW),
        .search_blk_w (SW),
        .search_blk_h (SH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .blk_in_valid (blk_in_valid),
        .blk_in_ready (blk_in_ready),
        .ref_blk      (ref_blk),
        .srch_blk     (srch_blk),
        .blk_index_in (blk_index_in),
        .xors         (xors),
        .sum          (sum),
        .out_coords   (out_coords),
        .blk_index_o  (blk_index_o),
        .sum_valid    (sum_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  coords;
        logic [255:0] x;
        logic [7:0]   s;
        logic [15:0]  tag;
    } exp_t;

    typedef struct {
        logic [255:0]  rblk;
        logic [1279:0] sblk;
        logic [15:0]   tag;
        bit            const_sum;
        logic [7:0]    sum_c;
        bit            has_zero;
        logic [15:0]   zero_co;
    } vec_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Per-tag observations gathered by the monitor.
    int          cnt       [16];
    int          first_cyc [16];
    int          last_cyc  [16];
    logic [15:0] first_co  [16];
    logic [15:0] last_co   [16];
    logic [7:0]  min_s     [16];
    logic [7:0]  max_s     [16];
    logic [15:0] min_co    [16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] model_cand(input logic [1279:0] s, input int v, input int h);
        logic [255:0] c;
        c = '0;
        for (int r = 0; r < BH; r++) begin
            for (int cc = 0; cc < BW; cc++) begin
                c[8'(r*BW + cc)] = s[11'((r + v)*SW + cc + h)];
            end
        end
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_block(input logic [255:0] r, input logic [1279:0] s, input logic [15:0] tag);
        exp_t e;
        int   pc;
        for (int v = 0; v < NV; v++) begin
            for (int h = NH - 1; h >= 0; h--) begin
                e.x      = model_cand(s, v, h) ^ r;
                pc       = $countones(e.x);
                e.s      = (pc > 255) ? 8'd255 : 8'(pc);
                e.coords = {8'(v), 8'(h)};
                e.tag    = tag;
                sb_q.push_back(e);
            end
        end
    endtask

    // Offer a block pair from a falling edge; returns on the falling edge
    // right after the accepting rising edge, with t_acc = that edge's index.
    task automatic send_block(input logic [255:0] r, input logic [1279:0] s,
                              input logic [15:0] tag, output int t_acc);
        bit done;
        done  = 1'b0;
        t_acc = -1000;
        ref_blk      = r;
        srch_blk     = s;
        blk_index_in = tag;
        blk_in_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            if (blk_in_ready) begin
                push_block(r, s, tag);
                t_acc = cyc + 1;
                done  = 1'b1;
            end
            @(negedge clk);
        end
        blk_in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout tag %0h ready never seen, expected ready", tag);
        end
    endtask

    task automatic wait_done(input int tag);
        for (int i = 0; i < 400 && cnt[tag] < NS; i++) @(negedge clk);
        check("result_count", 32'(cnt[tag]), 32'(NS));
    endtask

    // Scoreboard monitor: every valid result pops one expected record.
    always @(negedge clk) begin
        exp_t e;
        int   t;
        if (!reset && sum_valid) begin
            t = int'(blk_index_o[3:0]);
            if (cnt[t] == 0) begin
                first_cyc[t] = cyc;
                first_co[t]  = out_coords;
            end
            last_cyc[t] = cyc;
            last_co[t]  = out_coords;
            cnt[t]++;
            if (sum < min_s[t]) begin
                min_s[t]  = sum;
                min_co[t] = out_coords;
            end
            if (sum > max_s[t]) max_s[t] = sum;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got coords %h tag %h, expected no result", out_coords, blk_index_o);
            end else begin
                e = sb_q.pop_front();
                if (out_coords !== e.coords || sum !== e.s || blk_index_o !== e.tag || xors !== e.x) begin
                    errors++;
                    $display("FAIL sb_result got coords %h sum %0d tag %h xors %h expected coords %h sum %0d tag %h xors %h",
                             out_coords, sum, blk_index_o, xors, e.coords, e.s, e.tag, e.x);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t          vecs [5];
        logic [1279:0] s1;
        logic [1279:0] s2;
        logic [255:0]  r2;
        int            t_acc;
        int            t_b;
        int            saved;

        for (int i = 0; i < 16; i++) begin
            cnt[i]   = 0;
            min_s[i] = 8'hFF;
            max_s[i] = 8'h00;
            min_co[i] = 16'hFFFF;
        end

        reset        = 1'b1;
        blk_in_valid = 1'b0;
        ref_blk      = '0;
        srch_blk     = '0;
        blk_index_in = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_sum_valid", 32'(sum_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_xors_nonzero", 32'(|xors), 32'd0);
        check("rst_coords", 32'(out_coords), 32'd0);
        check("rst_blk_index", 32'(blk_index_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after_release", 32'(blk_in_ready), 32'd1);

        s1 = '0;
        s2 = '0;
        r2 = '0;
        for (int k = 0; k < 40; k++) begin
            s1 = {s1[1247:0], 32'($urandom())};
            s2 = {s2[1247:0], 32'($urandom())};
        end
        for (int k = 0; k < 8; k++) r2 = {r2[223:0], 32'($urandom())};

        vecs[0] = '{rblk: '0, sblk: '0, tag: 16'h0002, const_sum: 1'b1, sum_c: 8'd0,
                    has_zero: 1'b0, zero_co: 16'h0000};
        vecs[1] = '{rblk: '1, sblk: '0, tag: 16'h0003, const_sum: 1'b1, sum_c: 8'd255,
                    has_zero: 1'b0, zero_co: 16'h0000};
        vecs[2] = '{rblk: model_cand(s1, 2, 10), sblk: s1, tag: 16'h0004, const_sum: 1'b0,
                    sum_c: 8'd0, has_zero: 1'b1, zero_co: 16'h020A};
        vecs[3] = '{rblk: r2, sblk: s2, tag: 16'h0005, const_sum: 1'b0, sum_c: 8'd0,
                    has_zero: 1'b0, zero_co: 16'h0000};
        vecs[4] = '{rblk: {64{4'b0101}}, sblk: '1, tag: 16'h0006, const_sum: 1'b1, sum_c: 8'd128,
                    has_zero: 1'b0, zero_co: 16'h0000};

        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i].rblk, vecs[i].sblk, vecs[i].tag, t_acc);
            while (cyc < t_acc + 191) @(negedge clk);
            check("ready_low_last_issue", 32'(blk_in_ready), 32'd0);
            @(negedge clk);
            check("ready_high_after_scan", 32'(blk_in_ready), 32'd1);
            wait_done(int'(vecs[i].tag));
            check("first_result_cycle", 32'(first_cyc[vecs[i].tag]), 32'(t_acc + 3));
            check("last_result_cycle", 32'(last_cyc[vecs[i].tag]), 32'(t_acc + 194));
            check("first_coords", 32'(first_co[vecs[i].tag]), 32'h002F);
            check("last_coords", 32'(last_co[vecs[i].tag]), 32'h0300);
            if (vecs[i].const_sum) begin
                check("const_sum_min", 32'(min_s[vecs[i].tag]), 32'(vecs[i].sum_c));
                check("const_sum_max", 32'(max_s[vecs[i].tag]), 32'(vecs[i].sum_c));
            end
            if (vecs[i].has_zero) begin
                check("match_sum", 32'(min_s[vecs[i].tag]), 32'd0);
                check("match_coords", 32'(min_co[vecs[i].tag]), 32'(vecs[i].zero_co));
            end
            repeat (3) @(negedge clk);
            check("hold_valid_low", 32'(sum_valid), 32'd0);
            check("hold_coords", 32'(out_coords), 32'h0300);
            check("hold_tag", 32'(blk_index_o), 32'(vecs[i].tag));
        end

        // Back-to-back blocks: second offered while the first is scanning.
        send_block(s1[255:0], s2, 16'h0000, t_acc);
        send_block(r2, s1, 16'h0001, t_b);
        check("b2b_accept_gap", 32'(t_b - t_acc), 32'd193);
        wait_done(0);
        wait_done(1);
        check("b2b_first_cycle", 32'(first_cyc[0]), 32'(t_acc + 3));
        check("b2b_idle_gap", 32'(first_cyc[1] - last_cyc[0]), 32'd2);
        check("b2b_second_first_coords", 32'(first_co[1]), 32'h002F);

        // Reset in the middle of a scan.
        send_block(r2, s2, 16'h000A, t_acc);
        for (int i = 0; i < 300 && cnt[10] < 50; i++) @(negedge clk);
        check("pre_reset_count_reached", 32'(cnt[10] >= 50), 32'd1);
        reset = 1'b1;
        #1;
        check("midrst_sum_valid", 32'(sum_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_xors_nonzero", 32'(|xors), 32'd0);
        check("midrst_coords", 32'(out_coords), 32'd0);
        check("midrst_tag", 32'(blk_index_o), 32'd0);
        sb_q.delete();
        saved = cnt[10];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready_after_release", 32'(blk_in_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("midrst_no_more_results", 32'(cnt[10]), 32'(saved));
        send_block('0, '0, 16'h000B, t_acc);
        wait_done(11);
        check("post_rst_first_coords", 32'(first_co[11]), 32'h002F);
        check("post_rst_first_cycle", 32'(first_cyc[11]), 32'(t_acc + 3));

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
